stereo_output_stage: RTL and testbench

Final stage of the FM receiver audio path. Pops one left and one right sample together from the left/right output FIFOs, which are fed by the volume-gain multipliers. Each sample is de-quantized with an arithmetic shift, rounded and saturated to the audio width. The result is presented as a stereo pair on a valid/ready interface, with a delivered-pair counter and a sticky channel-skew error flag.

---
 rtl/fm_audio_pkg.sv | 24 ++
 rtl/audio_quantize.sv | 53 +++++
 rtl/stereo_output_stage.sv | 165 ++++++++++++++++
 tb/tb_stereo_output_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fm_audio_pkg
// Description : Shared types and default constants for the FM receiver audio
//               output path (stage state encoding, output width, quant shift).
// Revision    : 1.0 - initial release
// ============================================================================
package fm_audio_pkg;

  // Default signed output sample width delivered to the audio consumer
  localparam int AUDIO_OUT_WIDTH = 16;

  // Default de-quantization right shift applied to gain-multiplier outputs
  localparam int AUDIO_QUANT_SHIFT = 10;

  // Output stage sequencing: wait for data, wait for FIFO read latency, present
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } audio_state_t;

endpackage : fm_audio_pkg
`default_nettype wire

// File: rtl/audio_quantize.sv
`default_nettype none
// ============================================================================
// Module      : audio_quantize
// Description : Combinational de-quantizer. Rounds a signed fixed-point sample
//               half toward +inf while shifting right by SHIFT, then
//               saturates the result to a signed OUT_WIDTH value.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_quantize
  import fm_audio_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = AUDIO_OUT_WIDTH,
  parameter int SHIFT      = AUDIO_QUANT_SHIFT
) (
  input  logic [DATA_WIDTH-1:0] sample_in,
  output logic [OUT_WIDTH-1:0]  sample_out
);

  // Rounding offset: one half of the least significant output step
  localparam logic signed [DATA_WIDTH:0] c_HALF = (DATA_WIDTH+1)'(1) << (SHIFT-1);

  // Output range limits expressed in the widened intermediate format
  localparam logic signed [DATA_WIDTH:0] c_MAX =
    {{(DATA_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH:0] c_MIN =
    {{(DATA_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // One extra bit of headroom keeps the rounding add from overflowing
  logic signed [DATA_WIDTH:0] w_ext;
  logic signed [DATA_WIDTH:0] w_sum;
  logic signed [DATA_WIDTH:0] w_shr;
  logic                       w_unused_high;

  assign w_ext = $signed({sample_in[DATA_WIDTH-1], sample_in});
  assign w_sum = w_ext + c_HALF;
  assign w_shr = w_sum >>> SHIFT;

  // High bits only matter through the range comparisons below
  assign w_unused_high = ^w_shr[DATA_WIDTH:OUT_WIDTH];

  // Clamp the rounded value into the signed output range
  always_comb begin
    sample_out = w_shr[OUT_WIDTH-1:0];
    if (w_shr > c_MAX) begin
      sample_out = c_MAX[OUT_WIDTH-1:0];
    end else if (w_shr < c_MIN) begin
      sample_out = c_MIN[OUT_WIDTH-1:0];
    end
  end

endmodule : audio_quantize
`default_nettype wire

// File: rtl/stereo_output_stage.sv
`default_nettype none
// ============================================================================
// Module      : stereo_output_stage
// Description : Pops left/right samples together from the output FIFOs,
//               de-quantizes them and presents the pair on a valid/ready
//               interface. Counts delivered pairs and flags sustained
//               one-sided FIFO occupancy as a sticky skew error.
// Revision    : 1.0 - initial release
// ============================================================================
module stereo_output_stage
  import fm_audio_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = AUDIO_OUT_WIDTH,
  parameter int SHIFT      = AUDIO_QUANT_SHIFT,
  parameter int SKEW_LIMIT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  left_empty,
  input  logic [DATA_WIDTH-1:0] left_dout,
  output logic                  left_rd_en,
  input  logic                  right_empty,
  input  logic [DATA_WIDTH-1:0] right_dout,
  output logic                  right_rd_en,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  left_audio,
  output logic [OUT_WIDTH-1:0]  right_audio,
  output logic [31:0]           sample_count,
  output logic                  skew_err
);

  localparam int                  c_SKEW_W   = $clog2(SKEW_LIMIT + 1);
  localparam logic [c_SKEW_W-1:0] c_SKEW_MAX = c_SKEW_W'(SKEW_LIMIT);

  audio_state_t          r_state;
  audio_state_t          w_next_state;
  logic                  w_rd_en;
  logic                  w_both_avail;
  logic                  w_one_sided;
  logic                  w_handshake;
  logic [OUT_WIDTH-1:0]  w_left_q;
  logic [OUT_WIDTH-1:0]  w_right_q;
  logic [c_SKEW_W-1:0]   r_skew_cnt;
  logic [c_SKEW_W-1:0]   w_skew_next;

  assign w_both_avail = !left_empty && !right_empty;
  assign w_one_sided  = left_empty ^ right_empty;

  // Outputs are registered on the WAIT->PRESENT edge, so PRESENT is valid
  assign out_valid   = (r_state == PRESENT);
  assign w_handshake = out_valid && out_ready;

  // Both FIFOs are always popped together
  assign left_rd_en  = w_rd_en;
  assign right_rd_en = w_rd_en;

  audio_quantize #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .SHIFT      (SHIFT)
  ) u_quant_left (
    .sample_in  (left_dout),
    .sample_out (w_left_q)
  );

  audio_quantize #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .SHIFT      (SHIFT)
  ) u_quant_right (
    .sample_in  (right_dout),
    .sample_out (w_right_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and pop request; pops are suppressed while in reset
  always_comb begin
    w_next_state = r_state;
    w_rd_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_both_avail) begin
          w_rd_en      = 1'b1;
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        w_next_state = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          if (w_both_avail) begin
            w_rd_en      = 1'b1;
            w_next_state = WAIT;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    if (rst) begin
      w_rd_en = 1'b0;
    end
  end

  // Capture the quantized pair when FIFO read data becomes valid
  always_ff @(posedge clk) begin
    if (rst) begin
      left_audio  <= '0;
      right_audio <= '0;
    end else if (r_state == WAIT) begin
      left_audio  <= w_left_q;
      right_audio <= w_right_q;
    end
  end

  // Delivered-pair counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_count <= '0;
    end else if (w_handshake) begin
      sample_count <= sample_count + 32'd1;
    end
  end

  // Skew counter next value: run while idle with exactly one FIFO occupied
  always_comb begin
    w_skew_next = '0;
    if ((r_state == IDLE) && w_one_sided) begin
      if (r_skew_cnt == c_SKEW_MAX) begin
        w_skew_next = r_skew_cnt;
      end else begin
        w_skew_next = r_skew_cnt + 1'b1;
      end
    end
  end

  // Skew counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skew_cnt <= '0;
      skew_err   <= 1'b0;
    end else begin
      r_skew_cnt <= w_skew_next;
      if (w_skew_next == c_SKEW_MAX) begin
        skew_err <= 1'b1;
      end
    end
  end

endmodule : stereo_output_stage
`default_nettype wire

// File: tb/tb_stereo_output_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_stereo_output_stage
// Description : Self-checking bench for stereo_output_stage with behavioural
//               left/right FIFOs (read data valid the cycle after pop).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stereo_output_stage;

  localparam int DW = 32;
  localparam int OW = 16;

  logic          clk;
  logic          rst;
  logic          left_empty;
  logic [DW-1:0] left_dout;
  logic          left_rd_en;
  logic          right_empty;
  logic [DW-1:0] right_dout;
  logic          right_rd_en;
  logic          out_ready;
  logic          out_valid;
  logic [OW-1:0] left_audio;
  logic [OW-1:0] right_audio;
  logic [31:0]   sample_count;
  logic          skew_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural FIFOs
  logic [DW-1:0] l_mem [64];
  logic [DW-1:0] r_mem [64];
  logic [5:0]    l_wr = '0;
  logic [5:0]    l_rd = '0;
  logic [5:0]    r_wr = '0;
  logic [5:0]    r_rd = '0;

  assign left_empty  = (l_wr == l_rd);
  assign right_empty = (r_wr == r_rd);

  stereo_output_stage #(
    .DATA_WIDTH (DW),
    .OUT_WIDTH  (OW),
    .SHIFT      (10),
    .SKEW_LIMIT (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .left_empty   (left_empty),
    .left_dout    (left_dout),
    .left_rd_en   (left_rd_en),
    .right_empty  (right_empty),
    .right_dout   (right_dout),
    .right_rd_en  (right_rd_en),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .left_audio   (left_audio),
    .right_audio  (right_audio),
    .sample_count (sample_count),
    .skew_err     (skew_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO read ports
  always @(posedge clk) begin
    if (left_rd_en) begin
      left_dout <= l_mem[l_rd];
      l_rd      <= l_rd + 6'd1;
    end
    if (right_rd_en) begin
      right_dout <= r_mem[r_rd];
      r_rd       <= r_rd + 6'd1;
    end
  end

  // Every pop must be paired, from non-empty FIFOs, and outside reset
  always @(negedge clk) begin
    #1;
    if (left_rd_en || right_rd_en) begin
      n_cmp++;
      if (!(left_rd_en && right_rd_en && !left_empty && !right_empty && !rst)) begin
        n_fail++;
        $display("FAIL rd_en_pairing: got l=%0b r=%0b le=%0b re=%0b rst=%0b required paired pop from non-empty FIFOs",
                 left_rd_en, right_rd_en, left_empty, right_empty, rst);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_left(input logic [DW-1:0] v);
    l_mem[l_wr] = v;
    l_wr = l_wr + 6'd1;
  endtask

  task automatic push_right(input logic [DW-1:0] v);
    r_mem[r_wr] = v;
    r_wr = r_wr + 6'd1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got out_valid=0 required 1 within 20 cycles", name);
    end
  endtask

  typedef struct {
    logic [DW-1:0] l_in;
    logic [DW-1:0] r_in;
    logic [OW-1:0] exp_l;
    logic [OW-1:0] exp_r;
  } vec_t;

  vec_t          vecs [6];
  logic [31:0]   exp_count;
  logic [5:0]    l_rd0;
  logic [5:0]    r_rd0;
  logic [OW-1:0] e_l;
  logic [OW-1:0] e_r;
  int            got;
  bit            prev_valid;

  initial begin
    vecs[0] = '{32'h0000_0400, 32'h0000_0200, 16'sd1,      16'sd1};
    vecs[1] = '{32'h0000_01FF, 32'hFFFF_FE00, 16'sd0,      16'sd0};
    vecs[2] = '{32'h0000_0000, 32'hFFFF_FDFF, 16'sd0,      -16'sd1};
    vecs[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 16'sd32767,  -16'sd32768};
    vecs[4] = '{32'h01FF_FC00, 32'hFE00_0000, 16'sd32767,  -16'sd32768};
    vecs[5] = '{32'h0000_0600, 32'hFFFF_FA00, 16'sd2,      -16'sd1};

    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid",    {31'd0, out_valid},   32'd0);
    check("rst_left_audio",   {16'd0, left_audio},  32'd0);
    check("rst_right_audio",  {16'd0, right_audio}, 32'd0);
    check("rst_sample_count", sample_count,         32'd0);
    check("rst_skew_err",     {31'd0, skew_err},    32'd0);
    check("rst_rd_en",        {30'd0, left_rd_en, right_rd_en}, 32'd0);
    rst       = 1'b0;
    exp_count = 32'd0;

    // Quantization vectors, one pair at a time from IDLE
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      push_left(vecs[i].l_in);
      push_right(vecs[i].r_in);
      wait_valid("vec");
      check($sformatf("vec%0d_left", i),  {16'd0, left_audio},  {16'd0, vecs[i].exp_l});
      check($sformatf("vec%0d_right", i), {16'd0, right_audio}, {16'd0, vecs[i].exp_r});
      @(negedge clk);
      exp_count = exp_count + 32'd1;
      check($sformatf("vec%0d_count", i), sample_count, exp_count);
      check($sformatf("vec%0d_valid_drop", i), {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back: eight preloaded pairs, valid every other cycle
    @(negedge clk);
    l_rd0 = l_rd;
    for (int k = 1; k <= 8; k++) begin
      push_left(DW'(k * 1024));
      push_right(DW'(-(k * 1024)));
    end
    got        = 0;
    prev_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (prev_valid) begin
          check("b2b_no_consecutive_valid", 32'd1, 32'd0);
        end
        check("b2b_valid_cycle", c, 2 + 2 * got);
        e_l = OW'(got + 1);
        e_r = -OW'(got + 1);
        check("b2b_left",  {16'd0, left_audio},  {16'd0, e_l});
        check("b2b_right", {16'd0, right_audio}, {16'd0, e_r});
        got++;
      end
      prev_valid = out_valid;
    end
    exp_count = exp_count + 32'd8;
    check("b2b_pairs",       got, 8);
    check("b2b_count",       sample_count, exp_count);
    check("b2b_pops",        {26'd0, 6'(l_rd - l_rd0)}, 32'd8);
    check("b2b_fifos_empty", {30'd0, left_empty, right_empty}, 32'd3);

    // Backpressure: pair held for 20 cycles, second pair waits in FIFO
    @(negedge clk);
    out_ready = 1'b0;
    l_rd0 = l_rd;
    r_rd0 = r_rd;
    push_left(32'h0000_0C00);
    push_right(32'h0000_1000);
    push_left(32'h0000_1400);
    push_right(32'h0000_1800);
    wait_valid("bp");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_valid_held", {31'd0, out_valid},   32'd1);
      check("bp_left_held",  {16'd0, left_audio},  32'd3);
      check("bp_right_held", {16'd0, right_audio}, 32'd4);
    end
    check("bp_count_unchanged", sample_count, exp_count);
    check("bp_left_pops",  {26'd0, 6'(l_rd - l_rd0)}, 32'd1);
    check("bp_right_pops", {26'd0, 6'(r_rd - r_rd0)}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    exp_count = exp_count + 32'd1;
    check("bp_release_count", sample_count, exp_count);
    wait_valid("bp2");
    check("bp2_left",  {16'd0, left_audio},  32'd5);
    check("bp2_right", {16'd0, right_audio}, 32'd6);
    @(negedge clk);
    exp_count = exp_count + 32'd1;
    check("bp2_count", sample_count, exp_count);
    check("bp_total_pops", {26'd0, 6'(l_rd - l_rd0)}, 32'd2);

    // Reset in the WAIT cycle discards the popped pair
    @(negedge clk);
    l_rd0 = l_rd;
    push_left(32'h0000_2000);
    push_right(32'h0000_2400);
    push_left(32'h0000_2800);
    push_right(32'h0000_2C00);
    @(negedge clk);
    check("rmid_popped_first", {26'd0, 6'(l_rd - l_rd0)}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rmid_valid",  {31'd0, out_valid},  32'd0);
    check("rmid_count",  sample_count,        32'd0);
    check("rmid_left",   {16'd0, left_audio}, 32'd0);
    check("rmid_no_pop", {26'd0, 6'(l_rd - l_rd0)}, 32'd1);
    rst = 1'b0;
    exp_count = 32'd0;
    wait_valid("rmid");
    check("rmid_next_left",  {16'd0, left_audio},  32'd10);
    check("rmid_next_right", {16'd0, right_audio}, 32'd11);
    @(negedge clk);
    exp_count = exp_count + 32'd1;
    check("rmid_next_count", sample_count, exp_count);

    // Skew: left holds one word, right stays empty
    @(negedge clk);
    l_rd0 = l_rd;
    push_left(32'h0000_3000);
    repeat (63) @(negedge clk);
    check("skew_low_63",   {31'd0, skew_err}, 32'd0);
    check("skew_no_pop_a", {26'd0, 6'(l_rd - l_rd0)}, 32'd0);
    repeat (2) @(negedge clk);
    check("skew_high_65",  {31'd0, skew_err}, 32'd1);
    check("skew_no_pop_b", {26'd0, 6'(l_rd - l_rd0)}, 32'd0);
    push_right(32'h0000_3400);
    wait_valid("skew");
    check("skew_pair_left",  {16'd0, left_audio},  32'd12);
    check("skew_pair_right", {16'd0, right_audio}, 32'd13);
    @(negedge clk);
    exp_count = exp_count + 32'd1;
    check("skew_count",  sample_count,       exp_count);
    check("skew_sticky", {31'd0, skew_err},  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_stereo_output_stage
`default_nettype wire
